// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared CPU definitions (divider/multiplier/control FSM states, default width)
package div_seq_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/div_seq_step.sv
// div_step: one restoring division iteration
// Ports: rem/quo = current partial remainder and quotient, dvs = |divisor| at WIDTH+1 bits,
//        rem_nx/quo_nx = remainder and quotient after this step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   dvs,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);
   logic [WIDTH:0] shifted, diff;
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - dvs;
      rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};
   end
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential signed restoring divider (MIPS DIV, truncation toward zero)
// Ports: clock, reset (async active-low), start, dividend, divisor in;
//        hi = remainder, lo = quotient, busy, done (1-cycle pulse), div0 (zero-divisor pulse with done) out
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_nx;
   logic [WIDTH-1:0] rem, quo, rem_nx, quo_nx, a_abs;
   logic [WIDTH:0]   dvs, b_ext, b_abs;
   logic [CW-1:0]    cnt;
   logic             neg_q, neg_r, div0_r, zero;

   assign zero  = divisor == '0;
   assign a_abs = dividend[WIDTH-1] ? -dividend : dividend;
   // sign-extended to WIDTH+1 so |-2^(WIDTH-1)| stays positive
   assign b_ext = {divisor[WIDTH-1], divisor};
   assign b_abs = b_ext[WIDTH] ? -b_ext : b_ext;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem(rem), .quo(quo), .dvs(dvs), .rem_nx(rem_nx), .quo_nx(quo_nx)
   );

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? (zero ? DONE : CALC) : IDLE;
         CALC:    state_nx = cnt == '0 ? FIX : CALC;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0_r <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               div0_r <= start && zero;
               if (start && !zero) begin
                  rem   <= '0;
                  quo   <= a_abs;
                  dvs   <= b_abs;
                  cnt   <= CW'(WIDTH - 1);
                  neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_r <= dividend[WIDTH-1];
               end
            end
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               lo <= neg_q ? -quo : quo;
               hi <= neg_r ? -rem : rem;
            end
            default: ;
         endcase
      end

   assign busy = state != IDLE;
   assign done = state == DONE;
   assign div0 = done && div0_r;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed table-driven bench for div_seq plus multi-cycle corner sequences
module tb_div_seq;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div0;
   int          tests = 0, fails = 0;

   typedef struct {
      logic [31:0] a, b, lo, hi;
   } vec_t;
   vec_t v[9];

   div_seq #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // issues one start; returns at the negedge of the done cycle (or after timeout)
   task automatic run(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   initial begin
      int lat, pulses;
      logic [31:0] cap_lo, cap_hi;
      v[0] = '{32'd100, 32'd7, 32'd14, 32'd2};
      v[1] = '{-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      v[2] = '{32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1};
      v[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      v[4] = '{-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE};
      v[5] = '{32'd0, 32'd5, 32'd0, 32'd0};
      v[6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      v[7] = '{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0};
      v[8] = '{32'hFFFF_FFFF, 32'd10, 32'd0, 32'hFFFF_FFFF};

      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset div0", {31'd0, div0}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      foreach (v[i]) begin
         run(v[i].a, v[i].b, lat);
         chk($sformatf("v%0d latency", i), lat, 34);
         chk($sformatf("v%0d lo", i), lo, v[i].lo);
         chk($sformatf("v%0d hi", i), hi, v[i].hi);
         chk($sformatf("v%0d div0", i), {31'd0, div0}, 32'd0);
         @(negedge clock);
         chk($sformatf("v%0d done width", i), {31'd0, done}, 32'd0);
         chk($sformatf("v%0d idle", i), {31'd0, busy}, 32'd0);
      end

      // zero divisor after 14/2: fast path, result untouched
      run(32'd100, 32'd7, lat);
      run(32'd5, 32'd0, lat);
      chk("div0 latency", lat, 1);
      chk("div0 flag", {31'd0, div0}, 32'd1);
      chk("div0 hi kept", hi, 32'd2);
      chk("div0 lo kept", lo, 32'd14);
      @(negedge clock);
      chk("div0 pulse width", {30'd0, done, div0}, 32'd0);

      // start re-pulsed during CALC is ignored
      @(negedge clock);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      pulses   = 0;
      cap_lo   = '0;
      cap_hi   = '0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (k == 5) begin
            dividend = 32'd50;
            divisor  = 32'd3;
            start    = 1'b1;
         end
         if (done) begin
            pulses++;
            cap_lo = lo;
            cap_hi = hi;
         end
      end
      start = 1'b0;
      chk("ignore pulses", pulses, 1);
      chk("ignore lo", cap_lo, 32'd14);
      chk("ignore hi", cap_hi, 32'd2);

      // async reset at CALC cycle 10 abandons the operation
      @(negedge clock);
      dividend = 32'd1000;
      divisor  = 32'd7;
      start    = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst hi", hi, 32'd0);
      chk("midrst lo", lo, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (done) pulses++;
      end
      chk("midrst no done", pulses, 0);
      run(32'd9, 32'd3, lat);
      chk("post rst latency", lat, 34);
      chk("post rst lo", lo, 32'd3);
      chk("post rst hi", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a division, sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH, the signed dividend (rs value).
REQ-006 SHALL have port divisor, input, WIDTH, the signed divisor (rt value).
REQ-007 SHALL have port hi, output, WIDTH, the registered remainder destined for HI.
REQ-008 SHALL have port lo, output, WIDTH, the registered quotient destined for LO.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking that hi/lo are valid or that div0 is reported; control uses it to raise HILOWrite.
REQ-011 SHALL have port div0, output, 1, a one-cycle pulse, coincident with done, flagging a zero divisor.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-013 SHALL, in IDLE with start=1 and divisor!=0 at edge t0, latch |dividend|, |divisor| and both operand signs, clear the partial remainder, load the iteration counter with WIDTH-1, and enter CALC.
REQ-014 SHALL, in IDLE with start=1 and divisor==0, go to DONE with div0 set; hi and lo SHALL be left unchanged.
REQ-015 SHALL, in CALC, perform one restoring step per cycle: shift the remainder left by 1 carrying in the quotient MSB, subtract the divisor, keep the difference if it is non-negative and set the quotient bit to 1, otherwise restore and set the bit to 0.
REQ-016 SHALL, in CALC, leave for FIX after exactly WIDTH steps (counter reaches 0).
REQ-017 SHALL, in FIX, write lo = quotient negated when the operand signs differ, and hi = remainder negated when the dividend was negative (truncation toward zero, MIPS semantics), then go to DONE.
REQ-018 SHALL, in DONE, assert done for exactly one cycle (and div0 if it was set) and then return to IDLE.
REQ-019 SHALL, for a normal division, assert done during the cycle following edge t0+WIDTH+1 (latency WIDTH+2 cycles from start to the done cycle, 34 for WIDTH=32).
REQ-020 SHALL, for the zero-divisor path, assert done and div0 during the cycle following edge t0.
REQ-021 SHALL ignore start whenever busy=1; the operands SHALL NOT be re-latched.
REQ-022 SHALL give quotient 0x80000000 and remainder 0 for 0x80000000 / 0xFFFFFFFF (two's-complement wrap, no trap).
REQ-023 SHALL hold hi and lo between operations; they change only in FIX.
REQ-024 SHALL perform all arithmetic at WIDTH+1 bits internally so that |-2^31| is represented without overflow.

Reset
REQ-025 SHALL, while reset=0, force state to IDLE and hi, lo, busy, done and div0 to 0, plus all internal registers to 0, regardless of clock.
REQ-026 SHALL, if reset is asserted mid-operation, abandon the division with no done pulse; the next start after release SHALL compute correctly.

Structure
REQ-027 SHALL take the state enumeration and the default WIDTH from the shared CPU package, reused by the multiplier and the control unit.
REQ-028 SHALL place a single restoring iteration (shift, subtract, select) in a combinational sub-module named div_step; the FSM, counter and registers stay in div_seq.

Verification
REQ-029 SHALL verify: start with 100 / 7 -> done 34 cycles later, lo=14, hi=2, div0=0.
REQ-030 SHALL verify: start with -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and 7 / -2 -> lo=0xFFFFFFFD, hi=1.
REQ-031 SHALL verify: start with 5 / 0 after a prior result 14/2 -> done and div0 in the next cycle, hi=2, lo=14 unchanged.
REQ-032 SHALL verify: start with 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL verify: start pulsed again with other operands at CALC cycle 5 -> ignored, the original result is delivered, and exactly one done pulse occurs.
REQ-034 SHALL verify: reset=0 at CALC cycle 10 -> busy, hi and lo are 0 immediately with no done; then 9 / 3 -> lo=3, hi=0.
